// File: rtl/div_req_sched.sv
// Request scheduler in front of a start/done serial divider: FIFO-buffers tagged
// requests, issues them one at a time, and resolves divide-by-zero locally.
// Optional macro DIVSCHED_FASTPATH_EN also resolves divisor==1 and dividend<divisor locally.
module div_req_sched #(
    parameter int DW    = 16,
    parameter int TAG_W = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DW-1:0]    req_dividend,
    input  logic [DW-1:0]    req_divisor,
    input  logic [TAG_W-1:0] req_tag,
    output logic             div_start,
    output logic [DW-1:0]    div_dividend,
    output logic [DW-1:0]    div_divisor,
    input  logic             div_done,
    input  logic [DW-1:0]    div_quotient,
    input  logic [DW-1:0]    div_remainder,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DW-1:0]    rsp_quotient,
    output logic [DW-1:0]    rsp_remainder,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_dbz,
    output logic             busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q;
    logic [DW-1:0]      fifo_dvd_q [DEPTH];
    logic [DW-1:0]      fifo_dvs_q [DEPTH];
    logic [TAG_W-1:0]   fifo_tag_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [PW:0]        count_q;
    logic [PW:0]        count_d;
    logic               req_ready_q;
    logic               div_start_q;
    logic [DW-1:0]      div_dividend_q;
    logic [DW-1:0]      div_divisor_q;
    logic               rsp_valid_q;
    logic [DW-1:0]      rsp_quotient_q;
    logic [DW-1:0]      rsp_remainder_q;
    logic [TAG_W-1:0]   rsp_tag_q;
    logic               rsp_dbz_q;
    logic               push_s;
    logic               pop_s;
    logic [DW-1:0]      head_dvd_s;
    logic [DW-1:0]      head_dvs_s;
    logic [TAG_W-1:0]   head_tag_s;

    assign push_s     = req_valid && req_ready_q;
    // The head leaves the FIFO only when its response handshakes, keeping responses in order.
    assign pop_s      = (state_q == RESP) && rsp_ready;
    assign head_dvd_s = fifo_dvd_q[rd_ptr_q];
    assign head_dvs_s = fifo_dvs_q[rd_ptr_q];
    assign head_tag_s = fifo_tag_q[rd_ptr_q];

    // Next FIFO occupancy from push/pop.
    always_comb begin
        count_d = count_q;
        if (push_s && !pop_s) begin
            count_d = count_q + (PW+1)'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - (PW+1)'(1);
        end else begin
            count_d = count_q;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_dvd_q[wr_ptr_q] <= req_dividend;
            fifo_dvs_q[wr_ptr_q] <= req_divisor;
            fifo_tag_q[wr_ptr_q] <= req_tag;
        end
    end

    // FIFO pointers, occupancy and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            req_ready_q <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q     <= count_d;
            req_ready_q <= (count_d != (PW+1)'(DEPTH));
        end
    end

    // Scheduler FSM with registered divider and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            div_start_q     <= 1'b0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_tag_q       <= '0;
            rsp_dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    div_start_q <= 1'b0;
                    if (count_q == '0) begin
                        state_q <= IDLE;
                    end else if (head_dvs_s == '0) begin
                        rsp_quotient_q  <= '1;
                        rsp_remainder_q <= head_dvd_s;
                        rsp_tag_q       <= head_tag_s;
                        rsp_dbz_q       <= 1'b1;
                        rsp_valid_q     <= 1'b1;
                        state_q         <= RESP;
`ifdef DIVSCHED_FASTPATH_EN
                    end else if (head_dvs_s == DW'(1)) begin
                        rsp_quotient_q  <= head_dvd_s;
                        rsp_remainder_q <= '0;
                        rsp_tag_q       <= head_tag_s;
                        rsp_dbz_q       <= 1'b0;
                        rsp_valid_q     <= 1'b1;
                        state_q         <= RESP;
                    end else if (head_dvd_s < head_dvs_s) begin
                        rsp_quotient_q  <= '0;
                        rsp_remainder_q <= head_dvd_s;
                        rsp_tag_q       <= head_tag_s;
                        rsp_dbz_q       <= 1'b0;
                        rsp_valid_q     <= 1'b1;
                        state_q         <= RESP;
`endif
                    end else begin
                        div_dividend_q <= head_dvd_s;
                        div_divisor_q  <= head_dvs_s;
                        div_start_q    <= 1'b1;
                        state_q        <= ISSUE;
                    end
                end
                ISSUE: begin
                    div_start_q <= 1'b0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    // A done pulse is only meaningful here; elsewhere it is ignored.
                    if (div_done) begin
                        rsp_quotient_q  <= div_quotient;
                        rsp_remainder_q <= div_remainder;
                        rsp_tag_q       <= head_tag_s;
                        rsp_dbz_q       <= 1'b0;
                        rsp_valid_q     <= 1'b1;
                        state_q         <= RESP;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= RESP;
                    end
                end
                default: begin
                    div_start_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign div_start     = div_start_q;
    assign div_dividend  = div_dividend_q;
    assign div_divisor   = div_divisor_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_quotient  = rsp_quotient_q;
    assign rsp_remainder = rsp_remainder_q;
    assign rsp_tag       = rsp_tag_q;
    assign rsp_dbz       = rsp_dbz_q;
    assign busy          = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_div_req_sched.sv
// Directed self-checking bench for div_req_sched with a behavioural 17-cycle divider.
module tb_div_req_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_dividend = 16'd0;
    logic [15:0] req_divisor = 16'd0;
    logic [3:0]  req_tag = 4'd0;
    logic        div_start;
    logic [15:0] div_dividend;
    logic [15:0] div_divisor;
    logic        div_done;
    logic [15:0] div_quotient;
    logic [15:0] div_remainder;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_quotient;
    logic [15:0] rsp_remainder;
    logic [3:0]  rsp_tag;
    logic        rsp_dbz;
    logic        busy;

    logic        model_done;
    logic        stray_done = 1'b0;
    logic        m_active;
    logic [4:0]  m_cnt;
    logic [15:0] m_a;
    logic [15:0] m_b;
    int          start_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    div_req_sched #(.DW(16), .TAG_W(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor), .req_tag(req_tag),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_tag(rsp_tag), .rsp_dbz(rsp_dbz), .busy(busy)
    );

    assign div_done = model_done | stray_done;

    // Behavioural serial divider, reset from the same source as the scheduler.
    always @(posedge clk) begin
        if (rst) begin
            m_active   <= 1'b0;
            m_cnt      <= 5'd0;
            model_done <= 1'b0;
        end else begin
            model_done <= 1'b0;
            if (m_active) begin
                if (m_cnt == 5'd1) begin
                    model_done    <= 1'b1;
                    div_quotient  <= m_a / m_b;
                    div_remainder <= m_a % m_b;
                    m_active      <= 1'b0;
                end
                m_cnt <= m_cnt - 5'd1;
            end else if (div_start) begin
                m_active <= 1'b1;
                m_cnt    <= 5'd17;
                m_a      <= div_dividend;
                m_b      <= div_divisor;
            end
        end
    end

    always @(posedge clk) begin
        if (div_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Drive one request and hold it until accepted; returns at accept edge + 1.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t, output bit ok);
        req_valid = 1'b1; req_dividend = a; req_divisor = b; req_tag = t;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({req_ready, div_start, rsp_valid, busy, rsp_dbz} !== 5'b10000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 10000", {req_ready, div_start, rsp_valid, busy, rsp_dbz});
        end
        checks++;
        if ({rsp_quotient, rsp_remainder, rsp_tag, div_dividend, div_divisor} !== 68'd0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {rsp_quotient, rsp_remainder, rsp_tag, div_dividend, div_divisor});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        bit ok;
        int s0;
        bit seen;
        rsp_ready = 1'b1;
        s0 = start_cnt;
        send(16'd100, 16'd7, 4'd3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_accept: got not accepted expected accepted"); end
        @(negedge clk);
        checks++;
        if (div_start !== 1'b0) begin errors++; $display("FAIL single_start_c1: got %b expected 0", div_start); end
        @(negedge clk);
        checks++;
        if ({div_start, div_dividend, div_divisor} !== {1'b1, 16'd100, 16'd7}) begin
            errors++; $display("FAIL single_start_c2: got %b %0d %0d expected 1 100 7", div_start, div_dividend, div_divisor);
        end
        @(negedge clk);
        checks++;
        if (div_start !== 1'b0) begin errors++; $display("FAIL single_start_c3: got %b expected 0", div_start); end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (div_done) seen = 1'b1;
        end
        checks++;
        if (!seen || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_done: got seen=%b valid=%b expected 1 0", seen, rsp_valid); end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_dbz} !== {1'b1, 16'd14, 16'd2, 4'd3, 1'b0}) begin
            errors++; $display("FAIL single_rsp: got v=%b q=%0d r=%0d t=%0d z=%b expected 1 14 2 3 0", rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_dbz);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, busy} !== 2'b00 || start_cnt - s0 != 1) begin
            errors++; $display("FAIL single_after: got v=%b busy=%b starts=%0d expected 0 0 1", rsp_valid, busy, start_cnt - s0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_dbz();
        bit ok;
        int s0;
        rsp_ready = 1'b1;
        s0 = start_cnt;
        send(16'h1234, 16'd0, 4'd5, ok);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL dbz_early: got %b expected 0", rsp_valid); end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_dbz} !== {1'b1, 16'hFFFF, 16'h1234, 4'd5, 1'b1}) begin
            errors++; $display("FAIL dbz_rsp: got v=%b q=%h r=%h t=%0d z=%b expected 1 ffff 1234 5 1", rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_dbz);
        end
        @(negedge clk);
        checks++;
        if (!ok || rsp_valid !== 1'b0 || start_cnt != s0) begin
            errors++; $display("FAIL dbz_after: got ok=%b v=%b starts=%0d expected 1 0 0", ok, rsp_valid, start_cnt - s0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_burst();
        logic [15:0] a_t [6] = '{16'd100, 16'd50, 16'd1000, 16'd7, 16'd65535, 16'd9};
        logic [15:0] b_t [6] = '{16'd7, 16'd0, 16'd10, 16'd3, 16'd2, 16'd1};
        logic [15:0] q_t [6] = '{16'd14, 16'hFFFF, 16'd100, 16'd2, 16'd32767, 16'd9};
        logic [15:0] r_t [6] = '{16'd2, 16'd50, 16'd0, 16'd1, 16'd1, 16'd0};
        logic        z_t [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bit ok;
        bit stuck;
        int n;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(a_t[i], b_t[i], 4'(i), ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL burst_accept%0d: got rejected expected accepted", i); end
        end
        req_valid = 1'b1; req_dividend = a_t[4]; req_divisor = b_t[4]; req_tag = 4'd4;
        stuck = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready !== 1'b0) stuck = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (!stuck) begin errors++; $display("FAIL burst_full: got req_ready=1 expected 0 while full"); end
        rsp_ready = 1'b1;
        n = 0;
        fork
            begin
                send(a_t[4], b_t[4], 4'd4, ok);
                send(a_t[5], b_t[5], 4'd5, ok);
            end
            begin
                for (int i = 0; i < 1000 && n < 6; i++) begin
                    @(negedge clk);
                    if (rsp_valid && rsp_ready) begin
                        checks++;
                        if ({rsp_tag, rsp_quotient, rsp_remainder, rsp_dbz} !== {4'(n), q_t[n], r_t[n], z_t[n]}) begin
                            errors++; $display("FAIL burst_rsp%0d: got t=%0d q=%0d r=%0d z=%b expected t=%0d q=%0d r=%0d z=%b",
                                n, rsp_tag, rsp_quotient, rsp_remainder, rsp_dbz, n, q_t[n], r_t[n], z_t[n]);
                        end
                        n++;
                    end
                end
            end
        join
        checks++;
        if (n != 6) begin errors++; $display("FAIL burst_count: got %0d expected 6", n); end
        @(posedge clk); #1;
    endtask

    task automatic test_toggle();
        logic [15:0] q_t [3] = '{16'hFFFF, 16'd7, 16'h0123};
        logic [15:0] r_t [3] = '{16'd20, 16'd2, 16'd4};
        bit ok;
        bit hold;
        bit stable;
        logic [36:0] prev;
        int n;
        rsp_ready = 1'b0;
        send(16'd20, 16'd0, 4'd8, ok);
        send(16'd30, 16'd4, 4'd9, ok);
        send(16'h1234, 16'h0010, 4'd10, ok);
        n = 0; hold = 1'b0; stable = 1'b1; prev = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (hold && prev !== {rsp_valid, rsp_quotient, rsp_remainder, rsp_tag}) stable = 1'b0;
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (n >= 3 || {rsp_tag, rsp_quotient, rsp_remainder} !== {4'(8 + n), q_t[n], r_t[n]}) begin
                    errors++; $display("FAIL toggle_rsp%0d: got t=%0d q=%h r=%h expected t=%0d of 3 responses", n, rsp_tag, rsp_quotient, rsp_remainder, 8 + n);
                end
                n++;
            end
            hold = rsp_valid && !rsp_ready;
            prev = {rsp_valid, rsp_quotient, rsp_remainder, rsp_tag};
            @(posedge clk); #1;
            rsp_ready = !rsp_ready;
        end
        checks++;
        if (n != 3 || !stable) begin errors++; $display("FAIL toggle_summary: got n=%0d stable=%b expected 3 1", n, stable); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        int n;
        rsp_ready = 1'b1;
        send(16'd500, 16'd3, 4'd7, ok);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (div_start) seen = 1'b1;
        end
        repeat (4) @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        checks++;
        if (!seen || {rsp_valid, busy, req_ready} !== 3'b001) begin
            errors++; $display("FAIL rstmid_clear: got seen=%b v/busy/rdy=%b expected 1 001", seen, {rsp_valid, busy, req_ready});
        end
        @(posedge clk); #1;
        send(16'd65535, 16'd255, 4'd2, ok);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (n != 0 || {rsp_tag, rsp_quotient, rsp_remainder, rsp_dbz} !== {4'd2, 16'd257, 16'd0, 1'b0}) begin
                    errors++; $display("FAIL rstmid_rsp: got n=%0d t=%0d q=%0d r=%0d expected one response t=2 q=257 r=0", n, rsp_tag, rsp_quotient, rsp_remainder);
                end
                n++;
            end
        end
        checks++;
        if (n != 1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", n); end
        @(posedge clk); #1;
    endtask

    task automatic test_stray();
        bit quiet;
        stray_done = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL stray_done: got response/busy expected idle"); end
        @(posedge clk); #1;
    endtask

    task automatic test_fastpath();
        bit ok;
        int s0;
        bit seen;
        rsp_ready = 1'b1;
        s0 = start_cnt;
`ifdef DIVSCHED_FASTPATH_EN
        send(16'd9, 16'd1, 4'd11, ok);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_dbz} !== {1'b1, 16'd9, 16'd0, 4'd11, 1'b0}) begin
            errors++; $display("FAIL fast_div1: got v=%b q=%0d r=%0d t=%0d z=%b expected 1 9 0 11 0", rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_dbz);
        end
        @(posedge clk); #1;
`endif
        send(16'd3, 16'd10, 4'd6, ok);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (!seen || {rsp_quotient, rsp_remainder, rsp_tag, rsp_dbz} !== {16'd0, 16'd3, 4'd6, 1'b0}) begin
            errors++; $display("FAIL small_rsp: got seen=%b q=%0d r=%0d t=%0d z=%b expected 1 0 3 6 0", seen, rsp_quotient, rsp_remainder, rsp_tag, rsp_dbz);
        end
        @(negedge clk);
        checks++;
`ifdef DIVSCHED_FASTPATH_EN
        if (start_cnt != s0) begin errors++; $display("FAIL fast_starts: got %0d expected 0", start_cnt - s0); end
`else
        if (start_cnt - s0 != 1) begin errors++; $display("FAIL small_starts: got %0d expected 1", start_cnt - s0); end
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_dbz();
        test_burst();
        test_toggle();
        test_reset_mid();
        test_stray();
        test_fastpath();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/div_req_sched.md
Name: div_req_sched

Overview:
Request scheduler that sits directly upstream of the team's 16-bit serial divider, which has a start/done interface, one operation at a time, and about 17 cycles of latency.
- Buffers tagged divide requests in a small FIFO and issues them to the divider one at a time.
- Captures the divider's done pulse and returns quotient, remainder and tag on a valid/ready response channel.
- Resolves divide-by-zero locally, without occupying the divider.

Parameters:
DW, 16, operand width; must match the divider.
TAG_W, 4, request tag width.
DEPTH, 4, request FIFO depth; power of two, at least 2.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_dividend  in  DW  dividend
req_divisor  in  DW  divisor
req_tag  in  TAG_W  caller tag, returned unchanged
div_start  out  1  one-cycle start pulse to the divider
div_dividend  out  DW  operand to the divider; stable while div_start is high
div_divisor  out  DW  operand to the divider; stable while div_start is high
div_done  in  1  divider done pulse
div_quotient  in  DW  divider quotient, valid with div_done
div_remainder  in  DW  divider remainder, valid with div_done
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted when rsp_valid && rsp_ready
rsp_quotient  out  DW  quotient
rsp_remainder  out  DW  remainder
rsp_tag  out  TAG_W  tag of the request being answered
rsp_dbz  out  1  divide-by-zero flag
busy  out  1  high when the FIFO is non-empty or the FSM is not in IDLE

Behaviour:
- Reset: one clock, synchronous active-high reset rst, sampled on the rising edge of clk.
- Reset values: FIFO empty; FSM in IDLE; req_ready=1; div_start=0; rsp_valid=0; busy=0; rsp_quotient, rsp_remainder, rsp_tag, rsp_dbz, div_dividend and div_divisor all 0.
- FIFO:
  - req_ready = !full; registered from the FIFO count.
  - A push while full is impossible by construction.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - Read and write pointers wrap modulo DEPTH.
- Ordering: the head entry stays in the FIFO until its response handshakes, so responses are strictly in request order.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - FIFO empty: stay in IDLE.
  - Head divisor == 0: load rsp_quotient = all ones, rsp_remainder = head dividend, rsp_dbz = 1, and go to RESP.
  - Otherwise: drive div_dividend/div_divisor from the head and go to ISSUE.
- ISSUE: div_start = 1 for exactly one cycle; go to WAIT.
- WAIT:
  - On div_done: capture div_quotient, div_remainder and the head tag, set rsp_dbz = 0, and go to RESP.
  - No timeout.
- RESP:
  - rsp_valid = 1; all rsp_* outputs held stable until the handshake.
  - On rsp_ready: pop the FIFO and go to IDLE.
  - rsp_valid drops in the following cycle.
- Latency:
  - div_start rises in the second cycle after the cycle that accepted a request into an empty, idle block.
  - rsp_valid rises in the cycle after div_done.
  - A divide-by-zero request raises rsp_valid in the second cycle after acceptance.
  - Back-to-back requests: the next div_start occurs no earlier than 2 cycles after the prior response handshake.
- Stray done: div_done seen outside WAIT is ignored.
- Reset mid-operation: the FIFO and FSM clear and any in-flight result is discarded. The divider reset must be driven from the same reset source (divider reset = !rst), so the divider is never left busy.
- Arithmetic: no widening; values pass through unchanged at DW bits.

Optional Feature:
Macro DIVSCHED_FASTPATH_EN.
- Defined: IDLE also resolves trivial cases locally and goes straight to RESP with rsp_dbz = 0. Priority order:
  1. divisor == 0: divide-by-zero, as above.
  2. divisor == 1: quotient = dividend, remainder = 0.
  3. dividend < divisor: quotient = 0, remainder = dividend.
- Fast-path cases have the same latency as divide-by-zero and issue no div_start.
- Undefined: only divisor == 0 is handled locally; all other requests go to the divider.

Test Plan:
- Single request 100/7, tag 3, rsp_ready held high -> one div_start pulse; response q=14, r=2, tag=3, dbz=0, one cycle after div_done.
- Request 0x1234/0, tag 5 -> no div_start; q=0xFFFF, r=0x1234, dbz=1, rsp_valid in the second cycle after acceptance.
- Burst of 6 requests (tags 0-5) with DEPTH=4 and rsp_ready low for 100 cycles -> req_ready low after 4 accepts; release rsp_ready and all 6 responses return in tag order with correct values.
- rsp_ready toggled 0/1 every cycle during responses -> rsp_* outputs stable while rsp_valid && !rsp_ready; no response lost or duplicated.
- rst asserted during WAIT, then request 65535/255 -> no response for the aborted request; new response q=257, r=0.
- With DIVSCHED_FASTPATH_EN: 9/1 -> q=9, r=0; 3/10 -> q=0, r=3; neither issues div_start. Without the macro, 3/10 issues div_start and still returns q=0, r=3.
